// File: rtl/video_pattern_gen.sv
// ---------------------------------------------------------------------------
// video_pattern_gen
//
// Video test-pattern source with a ready/valid 24-bit pixel stream. It emits
// a WIDTH x HEIGHT raster, row-major, and repeats it forever. The pattern mode
// and the solid colour are latched at frame boundaries. A change on those
// inputs therefore takes effect at the next pixel (0,0).
//
// Parameters:
//   WIDTH       active pixels per line (>= 8)
//   HEIGHT      active lines per frame (>= 2)
//   CHECK_LOG2  checkerboard cell edge = 2**CHECK_LOG2 pixels
//               (must index inside both the x and y counters)
//   GRAD_SHIFT  gradient level = x_eff >> GRAD_SHIFT, truncated to 8 bits
//
// Ports:
//   clock        pixel clock
//   reset        asynchronous, active-high reset
//   mode         0 solid, 1 colour bars, 2 checkerboard, 3 grey gradient
//   solid_color  {R,G,B} used in mode 0
//   video        registered pixel {R[23:16],G[15:8],B[7:0]}
//   video_valid  pixel on video is valid (stays high after the first cycle)
//   video_ready  consumer accepts the pixel this cycle
//   frame_done   one-cycle pulse after the last pixel of a frame transfers
//
// Optional feature (macro PATTERN_GEN_SCROLL_EN):
//   A per-frame horizontal offset makes modes 1-3 scroll left by one pixel
//   per frame. When the macro is not defined, x_eff = x.
// ---------------------------------------------------------------------------
module video_pattern_gen #(
   parameter int WIDTH      = 800,
   parameter int HEIGHT     = 600,
   parameter int CHECK_LOG2 = 5,
   parameter int GRAD_SHIFT = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [1:0]  mode,
   input  logic [23:0] solid_color,
   output logic [23:0] video,
   output logic        video_valid,
   input  logic        video_ready,
   output logic        frame_done
);

   localparam int XW = $clog2(WIDTH);
   localparam int YW = $clog2(HEIGHT);
   localparam int BW = WIDTH / 8;
   localparam logic [XW-1:0] X_LAST  = XW'(WIDTH - 1);
   localparam logic [YW-1:0] Y_LAST  = YW'(HEIGHT - 1);
   localparam logic [XW-1:0] BW_LAST = XW'(BW - 1);

   // Effective x position, with the colour-bar index and the position inside
   // the bar tracked incrementally so that no divider is needed.
   typedef struct packed {
      logic [XW-1:0] xe;
      logic [2:0]    idx;
      logic [XW-1:0] pos;
   } bar_t;

   // Advances x_eff by one and wraps WIDTH-1 -> 0. Bar 7 absorbs the
   // remainder pixels, so its position counter keeps running past BW-1.
   function automatic bar_t bar_step(input bar_t b);
      bar_t n;
      n = b;
      if (b.xe == X_LAST) begin
         n = '0;
      end else begin
         n.xe = b.xe + XW'(1);
         if (b.pos == BW_LAST && b.idx != 3'd7) begin
            n.idx = b.idx + 3'd1;
            n.pos = '0;
         end else begin
            n.pos = b.pos + XW'(1);
         end
      end
      return n;
   endfunction

   function automatic logic [23:0] pixel(input logic [1:0]    md,
                                         input logic [23:0]   col,
                                         input bar_t          b,
                                         input logic [YW-1:0] yy);
      logic [XW-1:0] sh;
      logic [7:0]    g;
      logic [23:0]   p;
      sh = b.xe >> GRAD_SHIFT;
      g  = 8'(sh);
      case (md)
         2'd0: p = col;
         2'd1: begin
            case (b.idx)
               3'd0:    p = 24'hFFFFFF;
               3'd1:    p = 24'hFFFF00;
               3'd2:    p = 24'h00FFFF;
               3'd3:    p = 24'h00FF00;
               3'd4:    p = 24'hFF00FF;
               3'd5:    p = 24'hFF0000;
               3'd6:    p = 24'h0000FF;
               default: p = 24'h000000;
            endcase
         end
         2'd2:    p = (b.xe[CHECK_LOG2] ^ yy[CHECK_LOG2]) ? 24'h000000 : 24'hFFFFFF;
         default: p = {g, g, g};
      endcase
      return p;
   endfunction

   logic [XW-1:0] x, x_n;
   logic [YW-1:0] y, y_n;
   bar_t          cur, b_n, off_n;
   logic [1:0]    mode_q, md_n;
   logic [23:0]   color_q, col_n, pix_n;
   logic          xfer, eol, eof, adv;

`ifdef PATTERN_GEN_SCROLL_EN
   // The scroll offset is held as a bar_t so that each line starts with the
   // correct bar index and bar position already known.
   bar_t off;

   always_comb begin
      off_n = off;
      if (xfer && eof) off_n = bar_step(off);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) off <= '0;
      else       off <= off_n;
   end
`else
   assign off_n = '0;
`endif

   always_comb begin
      xfer  = video_valid & video_ready;
      eol   = (x == X_LAST);
      eof   = eol && (y == Y_LAST);
      adv   = !video_valid || xfer;
      x_n   = x;
      y_n   = y;
      b_n   = cur;
      md_n  = mode_q;
      col_n = color_q;
      if (!video_valid) begin
         // First cycle out of reset: start a frame using the live inputs.
         x_n   = '0;
         y_n   = '0;
         b_n   = off_n;
         md_n  = mode;
         col_n = solid_color;
      end else if (xfer) begin
         if (eol) begin
            x_n = '0;
            b_n = off_n;
            if (eof) begin
               y_n   = '0;
               md_n  = mode;
               col_n = solid_color;
            end else begin
               y_n = y + YW'(1);
            end
         end else begin
            x_n = x + XW'(1);
            b_n = bar_step(cur);
         end
      end
      pix_n = pixel(md_n, col_n, b_n, y_n);
   end

   // The next pixel is registered on the same edge that accepts the current
   // pixel, so the stream has no bubbles.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         x           <= '0;
         y           <= '0;
         cur         <= '0;
         mode_q      <= '0;
         color_q     <= '0;
         video       <= '0;
         video_valid <= 1'b0;
         frame_done  <= 1'b0;
      end else begin
         video_valid <= 1'b1;
         frame_done  <= xfer & eof;
         mode_q      <= md_n;
         color_q     <= col_n;
         if (adv) begin
            x     <= x_n;
            y     <= y_n;
            cur   <= b_n;
            video <= pix_n;
         end
      end
   end

endmodule

// File: tb/tb_video_pattern_gen.sv
module tb_video_pattern_gen;

   localparam int W    = 100;
   localparam int H    = 34;
   localparam int CL   = 5;
   localparam int GS   = 2;
   localparam int BWID = W / 8;

   logic        clock = 1'b0;
   logic        reset;
   logic [1:0]  mode;
   logic [23:0] solid_color;
   logic [23:0] video;
   logic        video_valid;
   logic        video_ready;
   logic        frame_done;

   int n_cmp = 0;
   int n_err = 0;

   // Reference state: position of the displayed pixel, latched mode/colour,
   // scroll offset and whether the stream has started since reset.
   int          mx, my, moff;
   logic [1:0]  m_mode;
   logic [23:0] m_col;
   logic        m_fd;
   logic        m_started;

   always #5 clock = ~clock;

   video_pattern_gen #(
      .WIDTH(W), .HEIGHT(H), .CHECK_LOG2(CL), .GRAD_SHIFT(GS)
   ) dut (
      .clock(clock),
      .reset(reset),
      .mode(mode),
      .solid_color(solid_color),
      .video(video),
      .video_valid(video_valid),
      .video_ready(video_ready),
      .frame_done(frame_done)
   );

   function automatic logic [23:0] exp_pix(input logic [1:0] md, input logic [23:0] col,
                                           input int x, input int y, input int off);
      int          xe, idx;
      logic [31:0] xv, yv;
      logic [7:0]  g;
      logic [23:0] p;
      xe = (x + off) % W;
      xv = xe;
      yv = y;
      g  = 8'(xe >> GS);
      case (md)
         2'd0: p = col;
         2'd1: begin
            idx = xe / BWID;
            if (idx > 7) idx = 7;
            case (idx)
               0:       p = 24'hFFFFFF;
               1:       p = 24'hFFFF00;
               2:       p = 24'h00FFFF;
               3:       p = 24'h00FF00;
               4:       p = 24'hFF00FF;
               5:       p = 24'hFF0000;
               6:       p = 24'h0000FF;
               default: p = 24'h000000;
            endcase
         end
         2'd2:    p = (xv[CL] ^ yv[CL]) ? 24'h000000 : 24'hFFFFFF;
         default: p = {g, g, g};
      endcase
      return p;
   endfunction

   function automatic logic [23:0] exp_now();
      return m_started ? exp_pix(m_mode, m_col, mx, my, moff) : 24'h0;
   endfunction

   task automatic model_reset();
      mx = 0; my = 0; moff = 0;
      m_mode = 2'd0; m_col = 24'h0; m_fd = 1'b0; m_started = 1'b0;
   endtask

   // One clock: advance the reference on the edge, then settle 1 time unit.
   task automatic cycle();
      logic rdy;
      rdy = video_ready;
      @(posedge clock);
      m_fd = 1'b0;
      if (!m_started) begin
         m_started = 1'b1;
         m_mode    = mode;
         m_col     = solid_color;
      end else if (rdy) begin
         if (mx == W - 1) begin
            mx = 0;
            if (my == H - 1) begin
               my     = 0;
               m_fd   = 1'b1;
               m_mode = mode;
               m_col  = solid_color;
`ifdef PATTERN_GEN_SCROLL_EN
               moff = (moff + 1) % W;
`endif
            end else begin
               my++;
            end
         end else begin
            mx++;
         end
      end
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      mode = 2'd1; solid_color = 24'h0; video_ready = 1'b0;
      reset = 1'b1;
      #2;
      n_cmp++; if (video_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", video_valid); end
      n_cmp++; if (video !== 24'h0) begin n_err++; $display("FAIL rst_video: got %h want 000000", video); end
      n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL rst_fd: got %b want 0", frame_done); end
      @(posedge clock); #1;
      n_cmp++; if (video_valid !== 1'b0) begin n_err++; $display("FAIL rst_hold_valid: got %b want 0", video_valid); end
      reset = 1'b0;
      model_reset();
      cycle();
      n_cmp++; if (video_valid !== 1'b1) begin n_err++; $display("FAIL first_valid: got %b want 1", video_valid); end
      n_cmp++; if (video !== 24'hFFFFFF) begin n_err++; $display("FAIL first_pixel: got %h want FFFFFF", video); end
      cycle();
      n_cmp++; if (video !== 24'hFFFFFF) begin n_err++; $display("FAIL hold_no_ready: got %h want FFFFFF", video); end
   endtask

   task automatic test_bars();
      logic [23:0] hv;
      logic        hchk;
      do_reset();
      mode = 2'd1; video_ready = 1'b1;
      cycle();
      for (int i = 0; i <= W; i++) begin
         n_cmp++;
         if (video !== exp_now()) begin
            n_err++; $display("FAIL bars_px%0d: got %h want %h", i, video, exp_now());
         end
         hchk = 1'b1;
         case (i)
            0, 11, W: hv = 24'hFFFFFF;
            12:       hv = 24'hFFFF00;
            83:       hv = 24'h0000FF;
            84, 99:   hv = 24'h000000;
            default:  begin hv = 24'h0; hchk = 1'b0; end
         endcase
         if (hchk) begin
            n_cmp++;
            if (video !== hv) begin n_err++; $display("FAIL bars_hand%0d: got %h want %h", i, video, hv); end
         end
         cycle();
      end
   endtask

   task automatic test_solid_frame();
      do_reset();
      mode = 2'd0; solid_color = 24'h123456; video_ready = 1'b1;
      cycle();
      for (int t = 0; t < W * H; t++) begin
         if (t == W * H / 2) solid_color = 24'hABCDEF;
         n_cmp++;
         if (video !== 24'h123456) begin n_err++; $display("FAIL solid_px%0d: got %h want 123456", t, video); end
         n_cmp++;
         if (frame_done !== 1'b0) begin n_err++; $display("FAIL solid_fd_early%0d: got %b want 0", t, frame_done); end
         cycle();
      end
      n_cmp++; if (frame_done !== 1'b1) begin n_err++; $display("FAIL solid_fd: got %b want 1", frame_done); end
      n_cmp++; if (video !== 24'hABCDEF) begin n_err++; $display("FAIL solid_newframe: got %h want ABCDEF", video); end
      cycle();
      n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL solid_fd_width: got %b want 0", frame_done); end
      n_cmp++; if (video !== 24'hABCDEF) begin n_err++; $display("FAIL solid_px1: got %h want ABCDEF", video); end
   endtask

   task automatic test_backpressure();
      logic [23:0] old_vid;
      logic        was, done;
      do_reset();
      mode = 2'd2; solid_color = 24'h0; video_ready = 1'b0;
      cycle();
      done = 1'b0;
      for (int c = 0; c < 20000 && !done; c++) begin
         video_ready = 1'($urandom_range(0, 1));
         old_vid = video;
         was = video_ready;
         cycle();
         n_cmp++;
         if (video_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid c%0d: got %b want 1", c, video_valid); end
         if (!was) begin
            n_cmp++;
            if (video !== old_vid) begin n_err++; $display("FAIL bp_stable c%0d: got %h want %h", c, video, old_vid); end
         end
         n_cmp++;
         if (video !== exp_now()) begin
            n_err++; $display("FAIL bp_px (%0d,%0d): got %h want %h", mx, my, video, exp_now());
         end
         if (was && mx == 32 && my == 0) begin
            n_cmp++;
            if (video !== 24'h000000) begin n_err++; $display("FAIL bp_32_0: got %h want 000000", video); end
         end
         if (was && mx == 32 && my == 32) begin
            n_cmp++;
            if (video !== 24'hFFFFFF) begin n_err++; $display("FAIL bp_32_32: got %h want FFFFFF", video); end
            done = 1'b1;
         end
      end
      n_cmp++;
      if (!done) begin n_err++; $display("FAIL bp_timeout: got not-reached want pixel (32,32)"); end
      video_ready = 1'b1;
   endtask

   task automatic test_mode_change();
      logic [23:0] want99;
`ifdef PATTERN_GEN_SCROLL_EN
      want99 = 24'h000000;
`else
      want99 = 24'h181818;
`endif
      do_reset();
      mode = 2'd1; video_ready = 1'b1;
      cycle();
      for (int t = 0; t < W * H; t++) begin
         if (t == 1000) mode = 2'd3;
         n_cmp++;
         if (video !== exp_now()) begin n_err++; $display("FAIL mc_px%0d: got %h want %h", t, video, exp_now()); end
         if (t == 1012) begin
            n_cmp++;
            if (video !== 24'hFFFF00) begin n_err++; $display("FAIL mc_still_bars: got %h want FFFF00", video); end
         end
         cycle();
      end
      n_cmp++; if (frame_done !== 1'b1) begin n_err++; $display("FAIL mc_fd: got %b want 1", frame_done); end
      for (int i = 0; i < W; i++) begin
         n_cmp++;
         if (video !== exp_now()) begin n_err++; $display("FAIL mc_new%0d: got %h want %h", i, video, exp_now()); end
         if (i == 0) begin
            n_cmp++; if (video !== 24'h000000) begin n_err++; $display("FAIL mc_0_0: got %h want 000000", video); end
         end
         if (i == 4) begin
            n_cmp++; if (video !== 24'h010101) begin n_err++; $display("FAIL mc_4_0: got %h want 010101", video); end
         end
         if (i == 99) begin
            n_cmp++; if (video !== want99) begin n_err++; $display("FAIL mc_99_0: got %h want %h", video, want99); end
         end
         cycle();
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      mode = 2'd1; video_ready = 1'b1;
      cycle();
      for (int t = 0; t < W * H - 10; t++) cycle();
      #1;
      reset = 1'b1;
      #1;
      n_cmp++; if (video_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid: got %b want 0", video_valid); end
      n_cmp++; if (video !== 24'h0) begin n_err++; $display("FAIL mid_rst_video: got %h want 000000", video); end
      @(posedge clock); #1;
      reset = 1'b0;
      model_reset();
      cycle();
      n_cmp++; if (video_valid !== 1'b1) begin n_err++; $display("FAIL mid_restart_valid: got %b want 1", video_valid); end
      n_cmp++; if (video !== 24'hFFFFFF) begin n_err++; $display("FAIL mid_restart_px: got %h want FFFFFF", video); end
      for (int i = 0; i < 20; i++) begin
         cycle();
         n_cmp++;
         if (frame_done !== 1'b0) begin n_err++; $display("FAIL mid_no_fd%0d: got %b want 0", i, frame_done); end
         n_cmp++;
         if (video !== exp_now()) begin n_err++; $display("FAIL mid_px%0d: got %h want %h", i, video, exp_now()); end
      end
   endtask

   task automatic test_scroll();
      logic [23:0] want5;
`ifdef PATTERN_GEN_SCROLL_EN
      want5 = 24'h010101;
`else
      want5 = 24'h000000;
`endif
      do_reset();
      mode = 2'd3; video_ready = 1'b1;
      cycle();
      for (int f = 1; f <= 5; f++) begin
         if (f == 1 || f == 2) begin
            n_cmp++;
            if (video !== 24'h000000) begin n_err++; $display("FAIL scr_f%0d_00: got %h want 000000", f, video); end
         end
         if (f == 5) begin
            n_cmp++;
            if (video !== want5) begin n_err++; $display("FAIL scr_f5_00: got %h want %h", video, want5); end
         end
         for (int t = 0; t < W * H; t++) begin
            n_cmp++;
            if (video !== exp_now()) begin
               n_err++; $display("FAIL scr_f%0d_px%0d: got %h want %h", f, t, video, exp_now());
            end
            cycle();
         end
         n_cmp++;
         if (frame_done !== 1'b1) begin n_err++; $display("FAIL scr_fd%0d: got %b want 1", f, frame_done); end
      end
   endtask

   initial begin
      reset = 1'b1; mode = 2'd0; solid_color = 24'h0; video_ready = 1'b0;
      model_reset();
      test_reset();
      test_bars();
      test_solid_frame();
      test_backpressure();
      test_mode_change();
      test_reset_mid();
      test_scroll();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
